dotprod: RTL and testbench
==========================

Name: dotprod

Overview:
- Sequential dot-product engine for two 8-element vectors of 32-bit operands, producing a 64-bit result.
- Uses a single multiply-accumulate (MAC) datapath: one element pair per clock, controlled by a start/done handshake.
- Sits as a compute peripheral; a controller drives the operands, pulses start, waits for done, then reads result.

Parameters:
- WIDTH, 32, operand width of a0..a7 and b0..b7.
- RES_WIDTH, 64, result width; must equal 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- a0..a7  input  WIDTH each  vector A elements, index 0..7.
- b0..b7  input  WIDTH each  vector B elements, index 0..7.
- start  input  1  request; sampled on a rising edge; single-cycle pulse expected, level tolerated.
- done  output  1  high when result is valid; level, not pulse.
- result  output  RES_WIDTH  sum over i of ai*bi.

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, done=0, result=0, accumulator=0, index=0. Reset has priority over everything, including mid-computation (that computation is aborted).
- States:
  - IDLE: waits for start.
  - RUN: 8 MAC cycles.
  - DONE: result valid and held.
- Start acceptance:
  - start=1 is accepted in IDLE or DONE.
  - On acceptance: a0..a7 and b0..b7 are latched into internal registers; accumulator=0; index=0; done=0; next state RUN.
  - Inputs may change freely after the accepting edge.
- RUN: each cycle, accumulator += A[index]*B[index] (full 2*WIDTH product) and index increments.
  - On the edge that adds element 7: result = final sum, done=1, state=DONE.
- Latency: done and result update on the 9th rising edge after the edge that accepted start. The total must be well under 200 cycles.
- start is ignored while in RUN. The operation is not restarted and the latched operands are not disturbed.
- done stays high and result stays constant until the next accepted start or a reset.
- During RUN, result holds the previous value (0 after reset). It changes only at completion.
- Arithmetic:
  - Operands are unsigned by default.
  - Products are exact 2*WIDTH bits.
  - The accumulation wraps modulo 2^RES_WIDTH; there is no saturation and no overflow flag.
- Boundary cases:
  - All-zero vectors give result=0 with normal latency.
  - Max operands (all 0xFFFFFFFF) give the wrapped 64-bit sum 8*(2^32-1)^2 mod 2^64.
  - start asserted on the same edge as rst: reset wins and the state stays IDLE.
  - start held high continuously: the block re-accepts on entering DONE. done is high for exactly one cycle in DONE, then the block restarts.

Optional Feature:
- Macro DOTPROD_SIGNED_EN.
- When defined: operands are two's-complement signed and products are sign-extended signed multiplies. result is the signed two's-complement sum, wrapped modulo 2^64.
- When undefined (default): unsigned arithmetic as above. Ports and timing are identical in both modes.

Test Plan:
- Reset 5 cycles, then A=[2,7,5,3,5,6,7,8], B=[8,7,6,5,4,3,2,1], 1-cycle start -> done high 9 edges later, result=170, held stable for the following cycles.
- A=[1..8], B=[8,7,6,5,4,3,2,1] issued back-to-back after the previous done -> done drops on the accepting edge, result=120.
- A=[1..8], B=[0,1,0,1,0,1,0,1] -> result=20; change inputs to garbage right after the start edge -> result still 20.
- All operands 0xFFFFFFFF -> result=0xFFFFFFF0_00000008 (unsigned wrap). With DOTPROD_SIGNED_EN, the same inputs (-1 each) -> result=8.
- start pulsed again mid-RUN -> ignored; completion timing and result unchanged.
- rst asserted mid-RUN -> next edge: done=0, result=0, IDLE; a subsequent start computes correctly.

Source files
------------

// File: rtl/dotprod.sv
// Sequential 8-element dot-product engine: one multiply-accumulate per clock behind a start/done handshake.
// Optional build macro DOTPROD_SIGNED_EN selects two's-complement operands; the default is unsigned.
module dotprod #(
  parameter int WIDTH     = 32,
  parameter int RES_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     a2,
  input  logic [WIDTH-1:0]     a3,
  input  logic [WIDTH-1:0]     a4,
  input  logic [WIDTH-1:0]     a5,
  input  logic [WIDTH-1:0]     a6,
  input  logic [WIDTH-1:0]     a7,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     b1,
  input  logic [WIDTH-1:0]     b2,
  input  logic [WIDTH-1:0]     b3,
  input  logic [WIDTH-1:0]     b4,
  input  logic [WIDTH-1:0]     b5,
  input  logic [WIDTH-1:0]     b6,
  input  logic [WIDTH-1:0]     b7,
  input  logic                 start,
  output logic                 done,
  output logic [RES_WIDTH-1:0] result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The product is registered, so RUN spans nine edges: eight products plus the final accumulate.
  localparam logic [3:0] LAST_IDX = 4'd8;

  logic [WIDTH-1:0]     a_in_s [8];
  logic [WIDTH-1:0]     b_in_s [8];
  logic [WIDTH-1:0]     a_q    [8];
  logic [WIDTH-1:0]     a_d    [8];
  logic [WIDTH-1:0]     b_q    [8];
  logic [WIDTH-1:0]     b_d    [8];
  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [3:0]           idx_q;
  logic [3:0]           idx_d;
  logic [RES_WIDTH-1:0] prod_q;
  logic [RES_WIDTH-1:0] prod_d;
  logic [RES_WIDTH-1:0] acc_q;
  logic [RES_WIDTH-1:0] acc_d;
  logic [RES_WIDTH-1:0] result_q;
  logic [RES_WIDTH-1:0] result_d;
  logic                 done_q;
  logic                 done_d;
  logic [RES_WIDTH-1:0] prod_sel_s;

  // Full-width product; the low RES_WIDTH bits of an extended multiply are exact for either signedness.
  function automatic logic [RES_WIDTH-1:0] mac_mul(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [RES_WIDTH-1:0] xe;
    logic [RES_WIDTH-1:0] ye;
`ifdef DOTPROD_SIGNED_EN
    xe = {{(RES_WIDTH-WIDTH){x[WIDTH-1]}}, x};
    ye = {{(RES_WIDTH-WIDTH){y[WIDTH-1]}}, y};
`else
    xe = {{(RES_WIDTH-WIDTH){1'b0}}, x};
    ye = {{(RES_WIDTH-WIDTH){1'b0}}, y};
`endif
    mac_mul = xe * ye;
  endfunction

  assign a_in_s[0] = a0;
  assign a_in_s[1] = a1;
  assign a_in_s[2] = a2;
  assign a_in_s[3] = a3;
  assign a_in_s[4] = a4;
  assign a_in_s[5] = a5;
  assign a_in_s[6] = a6;
  assign a_in_s[7] = a7;
  assign b_in_s[0] = b0;
  assign b_in_s[1] = b1;
  assign b_in_s[2] = b2;
  assign b_in_s[3] = b3;
  assign b_in_s[4] = b4;
  assign b_in_s[5] = b5;
  assign b_in_s[6] = b6;
  assign b_in_s[7] = b7;

  assign prod_sel_s = mac_mul(a_q[idx_q[2:0]], b_q[idx_q[2:0]]);

  // Next-state, operand latch and MAC datapath.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
    end
    state_d  = state_q;
    idx_d    = idx_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            a_d[i] = a_in_s[i];
            b_d[i] = b_in_s[i];
          end
          idx_d   = 4'd0;
          prod_d  = {RES_WIDTH{1'b0}};
          acc_d   = {RES_WIDTH{1'b0}};
          done_d  = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          result_d = acc_q + prod_q;
          done_d   = 1'b1;
          idx_d    = 4'd0;
          state_d  = ST_DONE;
        end else begin
          // prod_q is zero on the first RUN edge, so no special case is needed for element 0.
          prod_d = prod_sel_s;
          acc_d  = acc_q + prod_q;
          idx_d  = idx_q + 4'd1;
        end
      end
      default: begin
        idx_d   = 4'd0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over any computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        a_q[i] <= {WIDTH{1'b0}};
        b_q[i] <= {WIDTH{1'b0}};
      end
      state_q  <= ST_IDLE;
      idx_q    <= 4'd0;
      prod_q   <= {RES_WIDTH{1'b0}};
      acc_q    <= {RES_WIDTH{1'b0}};
      result_q <= {RES_WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
      state_q  <= state_d;
      idx_q    <= idx_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_dotprod.sv
// Directed self-checking bench for dotprod: latency, hold, back-to-back, boundaries and reset abort.
module tb_dotprod;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] av [8];
  logic [31:0] bv [8];
  logic        done;
  logic [63:0] result;

  int checks;
  int errors;
  logic [63:0] prev_res;

  dotprod dut (
    .clk(clk), .rst(rst),
    .a0(av[0]), .a1(av[1]), .a2(av[2]), .a3(av[3]),
    .a4(av[4]), .a5(av[5]), .a6(av[6]), .a7(av[7]),
    .b0(bv[0]), .b1(bv[1]), .b2(bv[2]), .b3(bv[3]),
    .b4(bv[4]), .b5(bv[5]), .b6(bv[6]), .b7(bv[7]),
    .start(start), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_garbage();
    for (int i = 0; i < 8; i++) begin
      av[i] = 32'hDEAD_0000 + 32'(i);
      bv[i] = 32'hBEEF_0000 + 32'(i);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_start_ignored cyc %0d: done %b want 0", i, done); end
    end
    prev_res = 64'd0;
  endtask

  task automatic test_basic();
    av = '{32'd2, 32'd7, 32'd5, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || result !== prev_res) begin
        errors++; $display("FAIL basic_run edge %0d: done %b result %h want 0/%h", i, done, result, prev_res);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd170) begin
      errors++; $display("FAIL basic_done: done %b result %0d want 1/170", done, result);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || result !== 64'd170) begin
        errors++; $display("FAIL basic_hold %0d: done %b result %0d want 1/170", i, done, result);
      end
    end
    prev_res = 64'd170;
  endtask

  task automatic test_back_to_back();
    av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || result !== prev_res) begin
      errors++; $display("FAIL b2b_accept: done %b result %h want 0/%h", done, result, prev_res);
    end
    for (int i = 1; i <= 8; i++) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_early: done %b want 0 at edge 8", done); end
    tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd120) begin
      errors++; $display("FAIL b2b_done: done %b result %0d want 1/120", done, result);
    end
    prev_res = 64'd120;
  endtask

  task automatic test_input_change();
    av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    set_garbage();
    for (int i = 1; i <= 8; i++) tick();
    tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd20) begin
      errors++; $display("FAIL input_change: done %b result %0d want 1/20", done, result);
    end
    prev_res = 64'd20;
  endtask

  task automatic test_max();
    logic [63:0] exp_v;
`ifdef DOTPROD_SIGNED_EN
    exp_v = 64'd8;
`else
    exp_v = 64'hFFFF_FFF0_0000_0008;
`endif
    for (int i = 0; i < 8; i++) begin
      av[i] = 32'hFFFF_FFFF;
      bv[i] = 32'hFFFF_FFFF;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    checks++;
    if (done !== 1'b1 || result !== exp_v) begin
      errors++; $display("FAIL max_operands: done %b result %h want 1/%h", done, result, exp_v);
    end
    av = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    bv = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    checks++;
    if (done !== 1'b0 || result !== exp_v) begin
      errors++; $display("FAIL zero_running: done %b result %h want 0/%h", done, result, exp_v);
    end
    tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd0) begin
      errors++; $display("FAIL zero_vectors: done %b result %h want 1/0", done, result);
    end
    prev_res = 64'd0;
  endtask

  task automatic test_start_mid_run();
    av = '{32'd2, 32'd7, 32'd5, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    set_garbage();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || result !== prev_res) begin
        errors++; $display("FAIL midrun_start edge %0d: done %b result %h want 0/%h", i, done, result, prev_res);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd170) begin
      errors++; $display("FAIL midrun_start_done: done %b result %0d want 1/170", done, result);
    end
    prev_res = 64'd170;
  endtask

  task automatic test_reset_mid_run();
    av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL midrun_reset: done %b result %h want 0/0", done, result);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrun_reset_aborted: done %b want 0", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd120) begin
      errors++; $display("FAIL after_reset_run: done %b result %0d want 1/120", done, result);
    end
    prev_res = 64'd120;
  endtask

  task automatic test_start_held();
    av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    start = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd20) begin
      errors++; $display("FAIL held_first: done %b result %0d want 1/20", done, result);
    end
    av = '{32'd2, 32'd7, 32'd5, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8};
    bv = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    tick();
    checks++;
    if (done !== 1'b0 || result !== 64'd20) begin
      errors++; $display("FAIL held_restart: done %b result %0d want 0/20", done, result);
    end
    for (int i = 1; i <= 9; i++) tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 64'd170) begin
      errors++; $display("FAIL held_second: done %b result %0d want 1/170", done, result);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || result !== 64'd170) begin
      errors++; $display("FAIL held_release: done %b result %0d want 1/170", done, result);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      av[i] = 32'd0;
      bv[i] = 32'd0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_input_change();
    test_max();
    test_start_mid_run();
    test_reset_mid_run();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
